// File: rtl/mul_dataflow_feeder.sv
// Feeder for the multiply/dot-product accelerator: splits an interleaved a/b operand
// stream into paired a/b streams and returns accelerator results through a small FIFO.
//
// state   | meaning
// IDLE    | waiting for start, job parameters not yet latched
// LOAD_A  | accepting the a beat of the next pair
// LOAD_B  | accepting the b beat of the next pair
// EMIT    | presenting a_hold/b_hold until both sides have handshaked
// DRAIN   | all pairs sent, waiting for the last result to leave the FIFO
module mul_dataflow_feeder #(
    parameter int MAC_CNT_LEN    = 4096,
    parameter int DATA_WIDTH     = 32,
    parameter int RES_FIFO_DEPTH = 2
) (
    input  logic                           ap_clk,
    input  logic                           ap_rst_n,
    input  logic                           start,
    input  logic                           reg_simple_mul,
    input  logic [$clog2(MAC_CNT_LEN)-1:0] reg_len,
    output logic                           busy,
    output logic                           done,
    input  logic                           in_TVALID,
    output logic                           in_TREADY,
    input  logic [DATA_WIDTH-1:0]          in_TDATA,
    output logic                           a_TVALID,
    input  logic                           a_TREADY,
    output logic [DATA_WIDTH-1:0]          a_TDATA,
    output logic                           b_TVALID,
    input  logic                           b_TREADY,
    output logic [DATA_WIDTH-1:0]          b_TDATA,
    input  logic                           d_TVALID,
    output logic                           d_TREADY,
    input  logic [DATA_WIDTH-1:0]          d_TDATA,
    output logic                           out_TVALID,
    input  logic                           out_TREADY,
    output logic [DATA_WIDTH-1:0]          out_TDATA
);
    localparam int LW = $clog2(MAC_CNT_LEN);
    localparam int CW = LW + 1;
    localparam int AW = $clog2(RES_FIFO_DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_EMIT,
        S_DRAIN
    } state_t;

    state_t                state_q, state_d;
    logic                  busy_q, busy_d;
    logic                  simple_q, simple_d;
    logic [LW-1:0]         len_q, len_d;
    logic [DATA_WIDTH-1:0] a_hold_q, a_hold_d;
    logic [DATA_WIDTH-1:0] b_hold_q, b_hold_d;
    logic                  sent_a_q, sent_a_d;
    logic                  sent_b_q, sent_b_d;
    logic [CW-1:0]         pair_cnt_q, pair_cnt_d;
    logic [CW-1:0]         res_in_cnt_q, res_in_cnt_d;
    logic [CW-1:0]         res_out_cnt_q, res_out_cnt_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] mem_q [RES_FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [RES_FIFO_DEPTH];

    logic [CW-1:0] n_val;
    logic [CW-1:0] e_val;
    logic [CW-1:0] pair_cnt_inc;
    logic [PW-1:0] fifo_cnt;
    logic          fifo_full;
    logic          fifo_empty;
    logic          in_hs;
    logic          a_hs;
    logic          b_hs;
    logic          d_hs;
    logic          out_hs;
    logic          a_sent_now;
    logic          b_sent_now;

    // Counters are one bit wider than reg_len so N = MAC_CNT_LEN is representable.
    assign n_val        = {1'b0, len_q} + CW'(1);
    assign e_val        = simple_q ? n_val : CW'(1);
    assign pair_cnt_inc = pair_cnt_q + CW'(1);

    assign fifo_cnt   = wr_ptr_q - rd_ptr_q;
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (fifo_cnt == PW'(RES_FIFO_DEPTH));

    assign busy       = busy_q;
    assign done       = (state_q == S_DRAIN) && (res_out_cnt_q == e_val);
    assign in_TREADY  = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
    assign a_TVALID   = (state_q == S_EMIT) && !sent_a_q;
    assign b_TVALID   = (state_q == S_EMIT) && !sent_b_q;
    assign a_TDATA    = a_hold_q;
    assign b_TDATA    = b_hold_q;
    assign d_TREADY   = busy_q && !fifo_full && (res_in_cnt_q < e_val);
    assign out_TVALID = !fifo_empty;
    assign out_TDATA  = mem_q[rd_ptr_q[AW-1:0]];

    assign in_hs      = in_TVALID && in_TREADY;
    assign a_hs       = a_TVALID && a_TREADY;
    assign b_hs       = b_TVALID && b_TREADY;
    assign d_hs       = d_TVALID && d_TREADY;
    assign out_hs     = out_TVALID && out_TREADY;
    assign a_sent_now = sent_a_q || a_hs;
    assign b_sent_now = sent_b_q || b_hs;

    always_comb begin
        state_d       = state_q;
        busy_d        = busy_q;
        simple_d      = simple_q;
        len_d         = len_q;
        a_hold_d      = a_hold_q;
        b_hold_d      = b_hold_q;
        sent_a_d      = sent_a_q;
        sent_b_d      = sent_b_q;
        pair_cnt_d    = pair_cnt_q;
        res_in_cnt_d  = res_in_cnt_q;
        res_out_cnt_d = res_out_cnt_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        for (int i = 0; i < RES_FIFO_DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end

        if (d_hs) begin
            mem_d[wr_ptr_q[AW-1:0]] = d_TDATA;
            wr_ptr_d                = wr_ptr_q + PW'(1);
            res_in_cnt_d            = res_in_cnt_q + CW'(1);
        end
        if (out_hs) begin
            rd_ptr_d      = rd_ptr_q + PW'(1);
            res_out_cnt_d = res_out_cnt_q + CW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d       = S_LOAD_A;
                    busy_d        = 1'b1;
                    simple_d      = reg_simple_mul;
                    len_d         = reg_len;
                    pair_cnt_d    = '0;
                    res_in_cnt_d  = '0;
                    res_out_cnt_d = '0;
                end
            end
            S_LOAD_A: begin
                if (in_hs) begin
                    a_hold_d = in_TDATA;
                    state_d  = S_LOAD_B;
                end
            end
            S_LOAD_B: begin
                if (in_hs) begin
                    b_hold_d = in_TDATA;
                    sent_a_d = 1'b0;
                    sent_b_d = 1'b0;
                    state_d  = S_EMIT;
                end
            end
            S_EMIT: begin
                sent_a_d = a_sent_now;
                sent_b_d = b_sent_now;
                if (a_sent_now && b_sent_now) begin
                    pair_cnt_d = pair_cnt_inc;
                    state_d    = (pair_cnt_inc == n_val) ? S_DRAIN : S_LOAD_A;
                end
            end
            S_DRAIN: begin
                if (res_out_cnt_q == e_val) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q       <= S_IDLE;
            busy_q        <= 1'b0;
            simple_q      <= 1'b0;
            len_q         <= '0;
            a_hold_q      <= '0;
            b_hold_q      <= '0;
            sent_a_q      <= 1'b0;
            sent_b_q      <= 1'b0;
            pair_cnt_q    <= '0;
            res_in_cnt_q  <= '0;
            res_out_cnt_q <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            for (int i = 0; i < RES_FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            simple_q      <= simple_d;
            len_q         <= len_d;
            a_hold_q      <= a_hold_d;
            b_hold_q      <= b_hold_d;
            sent_a_q      <= sent_a_d;
            sent_b_q      <= sent_b_d;
            pair_cnt_q    <= pair_cnt_d;
            res_in_cnt_q  <= res_in_cnt_d;
            res_out_cnt_q <= res_out_cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            for (int i = 0; i < RES_FIFO_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule
